clock_set_ctrl: RTL and testbench

//  Time-set controller for the digital clock. Debounces the four user switches and runs an edit FSM.
//  The user adjusts hours/minutes in BCD while the watch counter is frozen, then commits.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/sw_debounce.sv | 77 +++++++
 rtl/clock_set_ctrl.sv | 147 ++++++++++++++
 tb/tb_clock_set_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-set controller.
// Edit states, LCD field codes, BCD limits and switch bit positions.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        EDIT_H = 2'b01,
        EDIT_M = 2'b10,
        COMMIT = 2'b11
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_HOUR = 2'b01;
    localparam logic [1:0] FIELD_MIN  = 2'b10;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;

    localparam int SW_MODE   = 0;
    localparam int SW_INC    = 1;
    localparam int SW_DEC    = 2;
    localparam int SW_CANCEL = 3;

endpackage

// File: rtl/sw_debounce.sv
// One switch: 2-FF synchroniser, counting debouncer, press pulse
// and optional hold-to-repeat pulses.
module sw_debounce #(
    parameter int DEB_CYCLES   = 500000,
    parameter int REPEAT_START = 25000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter bit EN_REPEAT    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_pulse
);

    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int RMAX = (REPEAT_START > REPEAT_RATE) ? REPEAT_START : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_level_d;
    logic          r_phase;
    logic          r_pulse;
    logic [DW-1:0] r_cnt;
    logic [RW-1:0] r_rcnt;

    logic          w_rise;
    logic          w_rep;
    logic [RW-1:0] w_rtgt;

    assign w_rise = r_level & ~r_level_d;
    // r_rcnt holds cycles elapsed since the last edge or repeat pulse
    assign w_rtgt = r_phase ? RW'(REPEAT_RATE) : RW'(REPEAT_START);
    assign w_rep  = EN_REPEAT && r_level && r_level_d && (r_rcnt == w_rtgt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_phase   <= 1'b0;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
            r_rcnt    <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_sw};
            r_level_d <= r_level;
            r_pulse   <= w_rise | w_rep;

            if (r_sync[1] != r_level) begin
                if (r_cnt == DW'(DEB_CYCLES - 1)) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + DW'(1);
                end
            end else begin
                r_cnt <= '0;
            end

            if (w_rise || w_rep) begin
                r_rcnt <= RW'(1);
            end else if (r_level && (r_rcnt != w_rtgt)) begin
                r_rcnt <= r_rcnt + RW'(1);
            end

            if (w_rise) begin
                r_phase <= 1'b0;
            end else if (w_rep) begin
                r_phase <= 1'b1;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: debounced switches drive an edit FSM that
// freezes the watch, steps hours/minutes in BCD and commits with load.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES   = 500000,
    parameter int REPEAT_START = 25000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_1hz,
    input  logic [3:0] sw_in,
    input  logic [5:0] cur_hour,
    input  logic [6:0] cur_min,
    output logic [5:0] set_hour,
    output logic [6:0] set_min,
    output logic       load,
    output logic       hold,
    output logic [1:0] edit_field,
    output logic       blink
);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00) return max;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    logic [3:0] w_pulse;

    for (genvar g = 0; g < 4; g++) begin : g_sw
        sw_debounce #(
            .DEB_CYCLES  (DEB_CYCLES),
            .REPEAT_START(REPEAT_START),
            .REPEAT_RATE (REPEAT_RATE),
            .EN_REPEAT   (g == SW_INC || g == SW_DEC)
        ) u_sw (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_sw   (sw_in[g]),
            .o_pulse(w_pulse[g])
        );
    end

    state_t     r_state;
    state_t     w_state_nx;
    logic [5:0] r_hour;
    logic [6:0] r_min;
    logic       r_blink;
    logic [5:0] w_hour_nx;
    logic [6:0] w_min_nx;
    logic       w_blink_nx;

    logic w_mode;
    logic w_inc;
    logic w_dec;
    logic w_cancel;

    logic [5:0] w_hour_up;
    logic [5:0] w_hour_dn;
    logic [6:0] w_min_up;
    logic [6:0] w_min_dn;

    assign w_mode   = w_pulse[SW_MODE];
    assign w_cancel = w_pulse[SW_CANCEL];
    // Simultaneous inc and dec cancel each other out
    assign w_inc    = w_pulse[SW_INC] & ~w_pulse[SW_DEC];
    assign w_dec    = w_pulse[SW_DEC] & ~w_pulse[SW_INC];

    assign w_hour_up = 6'(bcd_inc({2'b00, r_hour}, HOUR_MAX));
    assign w_hour_dn = 6'(bcd_dec({2'b00, r_hour}, HOUR_MAX));
    assign w_min_up  = 7'(bcd_inc({1'b0, r_min}, MIN_MAX));
    assign w_min_dn  = 7'(bcd_dec({1'b0, r_min}, MIN_MAX));

    always_comb begin
        w_state_nx = r_state;
        w_hour_nx  = r_hour;
        w_min_nx   = r_min;
        unique case (r_state)
            RUN: begin
                if (w_mode) begin
                    w_state_nx = EDIT_H;
                    w_hour_nx  = cur_hour;
                    w_min_nx   = cur_min;
                end
            end
            EDIT_H: begin
                if (w_cancel) w_state_nx = RUN;
                else if (w_mode) w_state_nx = EDIT_M;
                else if (w_inc) w_hour_nx = w_hour_up;
                else if (w_dec) w_hour_nx = w_hour_dn;
            end
            EDIT_M: begin
                if (w_cancel) w_state_nx = RUN;
                else if (w_mode) w_state_nx = COMMIT;
                else if (w_inc) w_min_nx = w_min_up;
                else if (w_dec) w_min_nx = w_min_dn;
            end
            COMMIT: w_state_nx = RUN;
            default: w_state_nx = RUN;
        endcase
    end

    always_comb begin
        w_blink_nx = 1'b0;
        if (w_state_nx == EDIT_H || w_state_nx == EDIT_M) begin
            w_blink_nx = (r_state == RUN) ? 1'b1 : (r_blink ^ en_1hz);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_hour  <= '0;
            r_min   <= '0;
            r_blink <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_hour  <= w_hour_nx;
            r_min   <= w_min_nx;
            r_blink <= w_blink_nx;
        end
    end

    always_comb begin
        edit_field = FIELD_NONE;
        unique case (r_state)
            EDIT_H:  edit_field = FIELD_HOUR;
            EDIT_M:  edit_field = FIELD_MIN;
            default: edit_field = FIELD_NONE;
        endcase
    end

    assign set_hour = r_hour;
    assign set_min  = r_min;
    assign load     = (r_state == COMMIT);
    assign hold     = (r_state != RUN);
    assign blink    = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/repeat timing.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_1hz = 1'b0;
    logic [3:0] sw_in = 4'b0000;
    logic [5:0] cur_hour = 6'h12;
    logic [6:0] cur_min = 7'h34;
    logic [5:0] set_hour;
    logic [6:0] set_min;
    logic       load;
    logic       hold;
    logic [1:0] edit_field;
    logic       blink;

    int n_chk = 0;
    int n_err = 0;

    int         load_cnt = 0;
    logic [5:0] ld_h = '0;
    logic [6:0] ld_m = '0;
    logic       load_d = 1'b0;
    logic       hold_at_load = 1'b0;
    logic       hold_after = 1'b1;

    clock_set_ctrl #(
        .DEB_CYCLES  (4),
        .REPEAT_START(8),
        .REPEAT_RATE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_1hz    (en_1hz),
        .sw_in     (sw_in),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .load      (load),
        .hold      (hold),
        .edit_field(edit_field),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        load_d <= load;
        if (load) begin
            load_cnt     <= load_cnt + 1;
            ld_h         <= set_hour;
            ld_m         <= set_min;
            hold_at_load <= hold;
        end
        if (load_d) hold_after <= hold;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 6 cycles high: one clean press, too short to reach auto-repeat
    task automatic press(input logic [3:0] m);
        sw_in = m;
        cyc(6);
        sw_in = 4'b0000;
        cyc(10);
    endtask

    initial begin
        cyc(3);
        chk("rst_hour", 32'(set_hour), 32'h00);
        chk("rst_min", 32'(set_min), 32'h00);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_field", 32'(edit_field), 32'd0);
        chk("rst_blink", 32'(blink), 32'd0);
        rst = 1'b0;
        cyc(2);

        press(4'b0001);
        chk("t1_hold", 32'(hold), 32'd1);
        chk("t1_hour", 32'(set_hour), 32'h12);
        chk("t1_min", 32'(set_min), 32'h34);
        chk("t1_field", 32'(edit_field), 32'd1);
        chk("t1_blink_on", 32'(blink), 32'd1);
        en_1hz = 1'b1;
        cyc(1);
        en_1hz = 1'b0;
        cyc(1);
        chk("t1_blink_tgl0", 32'(blink), 32'd0);
        en_1hz = 1'b1;
        cyc(1);
        en_1hz = 1'b0;
        cyc(1);
        chk("t1_blink_tgl1", 32'(blink), 32'd1);
        for (int i = 0; i < 12; i++) press(4'b0010);
        chk("t1_hour_wrap", 32'(set_hour), 32'h00);
        press(4'b0100);
        chk("t1_hour_dec", 32'(set_hour), 32'h23);

        for (int i = 0; i < 20; i++) begin
            sw_in[1] = ~sw_in[1];
            cyc(2);
        end
        sw_in = 4'b0000;
        cyc(10);
        chk("t3_hour", 32'(set_hour), 32'h23);
        chk("t3_min", 32'(set_min), 32'h34);
        chk("t3_field", 32'(edit_field), 32'd1);

        press(4'b0110);
        chk("t4_incdec", 32'(set_hour), 32'h23);
        chk("t4_field_h", 32'(edit_field), 32'd1);
        press(4'b0011);
        chk("t4_field_m", 32'(edit_field), 32'd2);
        chk("t4_hour", 32'(set_hour), 32'h23);
        chk("t4_min", 32'(set_min), 32'h34);

        for (int i = 0; i < 35; i++) press(4'b0100);
        chk("t2_min59", 32'(set_min), 32'h59);
        press(4'b0010);
        chk("t2_min00", 32'(set_min), 32'h00);
        chk("t2_hour", 32'(set_hour), 32'h23);
        press(4'b0001);
        chk("t2_load_cnt", 32'(load_cnt), 32'd1);
        chk("t2_load_h", 32'(ld_h), 32'h23);
        chk("t2_load_m", 32'(ld_m), 32'h00);
        chk("t2_hold_at_load", 32'(hold_at_load), 32'd1);
        chk("t2_hold_after", 32'(hold_after), 32'd0);
        chk("t2_hold", 32'(hold), 32'd0);
        chk("t2_field", 32'(edit_field), 32'd0);

        press(4'b0001);
        press(4'b0001);
        chk("t5_in_edit_m", 32'(edit_field), 32'd2);
        press(4'b1000);
        chk("t5_cancel_hold", 32'(hold), 32'd0);
        chk("t5_cancel_field", 32'(edit_field), 32'd0);
        chk("t5_cancel_load", 32'(load_cnt), 32'd1);
        chk("t5_cancel_blink", 32'(blink), 32'd0);
        press(4'b0001);
        chk("t5_edit_hold", 32'(hold), 32'd1);
        rst = 1'b1;
        cyc(1);
        chk("t5_rst_hour", 32'(set_hour), 32'h00);
        chk("t5_rst_min", 32'(set_min), 32'h00);
        chk("t5_rst_load", 32'(load), 32'd0);
        chk("t5_rst_hold", 32'(hold), 32'd0);
        chk("t5_rst_field", 32'(edit_field), 32'd0);
        chk("t5_rst_blink", 32'(blink), 32'd0);
        rst = 1'b0;
        cyc(2);

        cur_hour = 6'h10;
        press(4'b0001);
        chk("t6_start", 32'(set_hour), 32'h10);
        // Edge pulse plus repeats at +8, +12, +16; released before +20
        sw_in = 4'b0010;
        cyc(18);
        sw_in = 4'b0000;
        cyc(12);
        chk("t6_repeat", 32'(set_hour), 32'h14);
        chk("t6_no_load", 32'(load_cnt), 32'd1);
        press(4'b1000);
        chk("t6_cancel", 32'(hold), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
